reg_file_mp: RTL

- Parametrised multi-port register file; next generation of the processor's 4 x 9-bit register file.
- Generalises data width and depth, adds a second write port with defined collision priority and selectable read-during-write forwarding.
- Adds an optional MIPS-style hardwired zero register, a registered read-valid strobe and a write-collision flag.
- Sits between decode (read addresses) and ALU/writeback (write ports).

---
 rtl/reg_file_mp.sv | 109 ++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// ============================================================================
//  Module   : reg_file_mp
//  Brief    : Parametrised 2-write / 2-read register file with registered
//             reads, selectable write-first forwarding and an optional
//             hardwired zero register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_mp #(
    parameter int                 DATA_W    = 9,
    parameter int                 ADDR_W    = 2,
    parameter int                 ZERO_REG  = 0,
    parameter int                 BYPASS    = 1,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd_valid,
    output logic              wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd0_data;
    logic [DATA_W-1:0] r_rd1_data;
    logic              r_rd_valid;
    logic              r_wr_conflict;

    logic              w_wr0_eff;
    logic              w_wr1_eff;
    logic              w_same_addr;
    logic [DATA_W-1:0] w_rd0_val;
    logic [DATA_W-1:0] w_rd1_val;

    // A write to the hardwired zero register is not an effective write.
    assign w_wr0_eff   = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
    assign w_wr1_eff   = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
    assign w_same_addr = (wr0_addr == wr1_addr);

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = r_mem[addr];
        if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
        end else if ((BYPASS != 0) && w_wr1_eff && (wr1_addr == addr)) begin
            val = wr1_data;
        end else if ((BYPASS != 0) && w_wr0_eff && (wr0_addr == addr)) begin
            val = wr0_data;
        end
        return val;
    endfunction

    always_comb begin
        w_rd0_val = read_port(rd0_addr);
        w_rd1_val = read_port(rd1_addr);
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_reg
            // Port 1 is checked first so it wins an address collision.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_mem[i] <= ((ZERO_REG != 0) && (i == 0)) ? '0 : RESET_VAL;
                end else if (w_wr1_eff && (wr1_addr == ADDR_W'(i))) begin
                    r_mem[i] <= wr1_data;
                end else if (w_wr0_eff && (wr0_addr == ADDR_W'(i))) begin
                    r_mem[i] <= wr0_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd0_data    <= '0;
            r_rd1_data    <= '0;
            r_rd_valid    <= 1'b0;
            r_wr_conflict <= 1'b0;
        end else begin
            if (rd_en) begin
                r_rd0_data <= w_rd0_val;
                r_rd1_data <= w_rd1_val;
            end
            r_rd_valid    <= rd_en;
            r_wr_conflict <= w_wr0_eff && w_wr1_eff && w_same_addr;
        end
    end

    assign rd0_data    = r_rd0_data;
    assign rd1_data    = r_rd1_data;
    assign rd_valid    = r_rd_valid;
    assign wr_conflict = r_wr_conflict;

endmodule

`default_nettype wire
